// File: rtl/gshare_pattern_table.sv
// Gshare pattern history table: 2-bit saturating counters indexed by GHR ^ PC.
// Combinational DEC lookup, one-stage DEC->EX carry, EX-stage training and mispredict flag.
module gshare_pattern_table #(
   parameter int unsigned BPRED_WIDTH  = 9,
   parameter int unsigned PC_WIDTH     = 32,
   parameter logic [1:0]  COUNTER_INIT = 2'b10
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_DEC_Is_Branch,
   input  logic [PC_WIDTH-1:0]    i_DEC_PC,
   input  logic [BPRED_WIDTH-1:0] i_Global_History,
   input  logic                   i_Stall,
   input  logic                   i_Flush,
   input  logic                   i_ALU_Branch_Valid,
   input  logic                   i_ALU_Branch_Outcome,
   output logic                   o_Prediction,
   output logic [BPRED_WIDTH-1:0] o_Index,
   output logic                   o_EX_Prediction,
   output logic                   o_Mispredict
);

   localparam int unsigned DEPTH = 1 << BPRED_WIDTH;

   logic [1:0]             pht [DEPTH];
   logic                   ex_valid;
   logic [BPRED_WIDTH-1:0] ex_index;
   logic                   do_update;
   logic [1:0]             cur_ex;
   logic [1:0]             next_ex;
   logic                   unused_pc;

   assign unused_pc = ^{i_DEC_PC[PC_WIDTH-1:BPRED_WIDTH+2], i_DEC_PC[1:0]};

   assign o_Index   = i_Global_History ^ i_DEC_PC[BPRED_WIDTH+1:2];
   assign do_update = i_ALU_Branch_Valid & ex_valid & ~i_Stall;

   always_comb begin
      cur_ex  = pht[ex_index];
      next_ex = cur_ex;
      if (i_ALU_Branch_Outcome) begin
         if (cur_ex != 2'b11) next_ex = cur_ex + 2'd1;
      end else begin
         if (cur_ex != 2'b00) next_ex = cur_ex - 2'd1;
      end
   end

   // Write-first bypass: a DEC lookup hitting the counter being trained sees the new value.
   always_comb begin
      o_Prediction = pht[o_Index][1];
      if (do_update && (ex_index == o_Index)) o_Prediction = next_ex[1];
   end

   assign o_Mispredict = i_Reset & do_update & (i_ALU_Branch_Outcome != o_EX_Prediction);

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         pht <= '{default: COUNTER_INIT};
      end else if (do_update) begin
         pht[ex_index] <= next_ex;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         ex_valid        <= 1'b0;
         ex_index        <= '0;
         o_EX_Prediction <= 1'b0;
      end else if (!i_Stall) begin
         ex_valid        <= i_DEC_Is_Branch & ~i_Flush;
         ex_index        <= o_Index;
         o_EX_Prediction <= o_Prediction;
      end
   end

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Directed-vector bench for gshare_pattern_table; driver queues expected outputs,
// a negedge monitor pops and compares them.
module tb_gshare_pattern_table;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        is_br = 1'b0;
   logic [31:0] pc = '0;
   logic [8:0]  ghr = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        av = 1'b0;
   logic        ao = 1'b0;
   logic        pred;
   logic [8:0]  idx;
   logic        ex_pred;
   logic        misp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [8:0] idx;
      logic       pred;
      logic       misp;
      logic       ex_pred;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   gshare_pattern_table #(
      .BPRED_WIDTH (9),
      .PC_WIDTH    (32),
      .COUNTER_INIT(2'b10)
   ) dut (
      .i_Clk               (clk),
      .i_Reset             (rst_n),
      .i_DEC_Is_Branch     (is_br),
      .i_DEC_PC            (pc),
      .i_Global_History    (ghr),
      .i_Stall             (stall),
      .i_Flush             (flush),
      .i_ALU_Branch_Valid  (av),
      .i_ALU_Branch_Outcome(ao),
      .o_Prediction        (pred),
      .o_Index             (idx),
      .o_EX_Prediction     (ex_pred),
      .o_Mispredict        (misp)
   );

   // One cycle: drive inputs just after the edge, queue what the outputs must be this cycle.
   task automatic step(input string tag, input logic r, input logic b, input logic [31:0] p,
                       input logic [8:0] g, input logic s, input logic f, input logic v,
                       input logic o, input logic [8:0] e_idx, input logic e_pred,
                       input logic e_misp, input logic e_expred);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = r; is_br = b; pc = p; ghr = g; stall = s; flush = f; av = v; ao = o;
      e.tag = tag; e.idx = e_idx; e.pred = e_pred; e.misp = e_misp; e.ex_pred = e_expred;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (idx !== e.idx) begin
            errors++;
            $display("FAIL %s index: got %h want %h", e.tag, idx, e.idx);
         end
         checks++;
         if (pred !== e.pred) begin
            errors++;
            $display("FAIL %s prediction: got %b want %b", e.tag, pred, e.pred);
         end
         checks++;
         if (misp !== e.misp) begin
            errors++;
            $display("FAIL %s mispredict: got %b want %b", e.tag, misp, e.misp);
         end
         checks++;
         if (ex_pred !== e.ex_pred) begin
            errors++;
            $display("FAIL %s ex_prediction: got %b want %b", e.tag, ex_pred, e.ex_pred);
         end
      end
   end

   initial begin
      //    tag         rst br pc     ghr    stl fl av ao   idx    pr ms ex
      step("reset",     0, 0, 32'h0,  9'h0,  0, 0, 0, 0, 9'h000, 1, 0, 0);
      step("t1_lookup", 1, 1, 32'h40, 9'h0,  0, 0, 0, 0, 9'h010, 1, 0, 0);
      step("t2_nt1",    1, 1, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 0, 1, 1);
      step("t2_nt2",    1, 1, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 0, 0, 0);
      step("t2_nt3",    1, 1, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 0, 0, 0);
      step("t3_tk1",    1, 1, 32'h40, 9'h0,  0, 0, 1, 1, 9'h010, 0, 1, 0);
      step("t3_tk2",    1, 1, 32'h40, 9'h0,  0, 0, 1, 1, 9'h010, 1, 1, 0);
      step("t3_tk3",    1, 1, 32'h40, 9'h0,  0, 0, 1, 1, 9'h010, 1, 0, 1);
      step("t3_tk4",    1, 1, 32'h40, 9'h0,  0, 0, 1, 1, 9'h010, 1, 0, 1);
      step("t3_nt",     1, 0, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 1, 1, 1);
      step("t3_read",   1, 0, 32'h40, 9'h0,  0, 0, 0, 0, 9'h010, 1, 0, 1);
      step("t4_idx0",   1, 1, 32'h40, 9'h10, 0, 0, 0, 0, 9'h000, 1, 0, 1);
      step("t4_nt1",    1, 1, 32'h40, 9'h10, 0, 0, 1, 0, 9'h000, 0, 1, 1);
      step("t4_nt2",    1, 0, 32'h40, 9'h10, 0, 0, 1, 0, 9'h000, 0, 0, 0);
      step("t4_other",  1, 1, 32'h40, 9'h0,  0, 0, 0, 0, 9'h010, 1, 0, 0);
      step("t5_look",   1, 1, 32'h80, 9'h0,  0, 0, 0, 0, 9'h020, 1, 0, 1);
      step("t5_nt",     1, 0, 32'h80, 9'h0,  0, 0, 1, 0, 9'h020, 0, 1, 1);
      step("t5_at01",   1, 1, 32'h80, 9'h0,  0, 0, 0, 0, 9'h020, 0, 0, 0);
      step("t5_bypass", 1, 1, 32'h80, 9'h0,  0, 0, 1, 1, 9'h020, 1, 1, 0);
      step("t5_expred", 1, 0, 32'h80, 9'h0,  0, 0, 0, 0, 9'h020, 1, 0, 1);
      step("t6_flush",  1, 1, 32'h40, 9'h0,  0, 1, 0, 0, 9'h010, 1, 0, 1);
      step("t6_ignore", 1, 0, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 1, 0, 1);
      step("t6_nowr",   1, 1, 32'h40, 9'h0,  0, 0, 0, 0, 9'h010, 1, 0, 1);
      step("t7_stall1", 1, 0, 32'h40, 9'h0,  1, 0, 1, 0, 9'h010, 1, 0, 1);
      step("t7_stall2", 1, 0, 32'h40, 9'h0,  1, 0, 1, 0, 9'h010, 1, 0, 1);
      step("t7_write",  1, 0, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 0, 1, 1);
      step("t7_after",  1, 0, 32'h40, 9'h0,  0, 0, 0, 0, 9'h010, 0, 0, 0);
      step("t8_load",   1, 1, 32'h40, 9'h0,  0, 0, 0, 0, 9'h010, 0, 0, 0);
      step("t8_inrst",  0, 1, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 1, 0, 0);
      step("t8_release",1, 0, 32'h40, 9'h0,  0, 0, 1, 0, 9'h010, 1, 0, 0);
      step("t8_idx0",   1, 0, 32'h40, 9'h10, 0, 0, 0, 0, 9'h000, 1, 0, 1);
      step("t8_idx20",  1, 0, 32'h80, 9'h0,  0, 0, 1, 1, 9'h020, 1, 0, 1);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
